// File: rtl/ps2_rx_pkg.sv
// Shared definitions for the PS/2 device-to-host receiver: FSM states, frame geometry,
// sticky-flag bit positions and the odd-parity helper.
package ps2_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1
    } state_t;

    localparam int FRAME_BITS = 11;
    // Edges shifted in RECV before the stop edge: 8 data bits + parity.
    localparam int PAYLOAD_BITS = FRAME_BITS - 2;

    localparam int FLAG_PARITY  = 0;
    localparam int FLAG_FRAME   = 1;
    localparam int FLAG_OVERRUN = 2;
    localparam int NUM_FLAGS    = 3;

    // Odd parity holds when data and parity bit together carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] data_par);
        return ^data_par;
    endfunction

endpackage

// File: rtl/ps2_rx_edge_filter.sv
// Input conditioning for the PS/2 lines: data synchroniser, run-length filter on the
// pad-registered clock, and a one-cycle pulse on each falling edge of the filtered clock.
module ps2_edge_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_core,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_bit
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          data_s1;
    logic          data_s2;
    logic          clk_s1;
    logic          filt;
    logic          filt_d;
    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            clk_s1  <= 1'b1;
        end else begin
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
            clk_s1  <= ps2_clk;
        end
    end

    // The filtered level only flips once the new value has been seen FILTER_LEN times in a row.
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            filt    <= 1'b1;
            filt_d  <= 1'b1;
            run_cnt <= '0;
        end else begin
            filt_d <= filt;
            if (clk_s1 == filt) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                filt    <= clk_s1;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + CW'(1);
            end
        end
    end

    assign fall     = filt_d & ~filt;
    assign data_bit = data_s2;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, buffers bytes in a small FIFO read
// through a valid/ack port, keeps sticky error flags and inhibits the PS/2 clock when full.
module ps2_rx
    import ps2_rx_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 4096,
    parameter int FIFO_AW    = 2
) (
    input  logic       clk_core,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    input  logic       err_clear,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       clk_inhibit
);

    localparam int TW    = $clog2(TIMEOUT);
    localparam int DEPTH = 2 ** FIFO_AW;

    logic fall;
    logic bit_s;
    logic edge_ok;

    ps2_edge_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_edge (
        .clk_core (clk_core),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .data_bit (bit_s)
    );

    // The device may still be clocking while we hold its clock low; those edges are not ours.
    assign edge_ok = fall & ~clk_inhibit;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    bitcnt;
    logic [9:0]    shreg;
    logic [TW-1:0] tcnt;
    logic          start;
    logic          shift;
    logic          stop;
    logic          tout;
    logic          eval_p;

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift     = 1'b0;
        stop      = 1'b0;
        tout      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (edge_ok && !bit_s) begin
                    state_nxt = ST_RECV;
                    start     = 1'b1;
                end
            end
            ST_RECV: begin
                if (edge_ok) begin
                    shift = 1'b1;
                    if (bitcnt == 4'(PAYLOAD_BITS)) begin
                        stop      = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    tout      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            bitcnt <= '0;
            tcnt   <= '0;
            eval_p <= 1'b0;
        end else begin
            if (start) begin
                bitcnt <= '0;
            end else if (shift) begin
                bitcnt <= bitcnt + 4'd1;
            end
            if (state == ST_IDLE || edge_ok || tout) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
            eval_p <= stop;
        end
    end

    // Stop bit is shifted too, so after the stop edge shreg = {stop, parity, data[7:0]}.
    always_ff @(posedge clk_core) begin
        if (shift) begin
            shreg <= {bit_s, shreg[9:1]};
        end
    end

    logic bad_stop;
    logic bad_par;
    logic push_req;

    assign bad_stop = eval_p & ~shreg[9];
    assign bad_par  = eval_p & shreg[9] & ~odd_parity_ok(shreg[8:0]);
    assign push_req = eval_p & shreg[9] & odd_parity_ok(shreg[8:0]);

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop   = rx_ack & ~empty;
    // A pop in the same cycle frees the slot the new byte lands in.
    assign push  = push_req & (~full | pop);
    assign drop  = push_req & full & ~pop;

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (FIFO_AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (FIFO_AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= shreg[7:0];
        end
    end

    assign rx_valid = ~empty;
    assign rx_data  = rx_valid ? mem[rd_ptr[FIFO_AW-1:0]] : 8'h00;

    logic [NUM_FLAGS-1:0] flags;
    logic [NUM_FLAGS-1:0] flag_set;

    always_comb begin
        flag_set               = '0;
        flag_set[FLAG_PARITY]  = bad_par;
        flag_set[FLAG_FRAME]   = bad_stop | tout;
        flag_set[FLAG_OVERRUN] = drop;
    end

    // A new error in the same cycle as err_clear survives the clear.
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            flags       <= '0;
            clk_inhibit <= 1'b0;
        end else begin
            flags       <= flag_set | (flags & {NUM_FLAGS{~err_clear}});
            clk_inhibit <= full && (state == ST_IDLE);
        end
    end

    assign parity_err = flags[FLAG_PARITY];
    assign frame_err  = flags[FLAG_FRAME];
    assign overrun    = flags[FLAG_OVERRUN];

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: drives PS/2 frames, keeps a byte scoreboard and checks
// flags, FIFO ordering, flow control, timeout, glitch rejection and mid-frame reset.
module tb_ps2_rx;

    logic       clk_core  = 1'b0;
    logic       reset_n   = 1'b0;
    logic       ps2_clk   = 1'b1;
    logic       ps2_data  = 1'b1;
    logic       rx_ack    = 1'b0;
    logic       err_clear = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       clk_inhibit;

    ps2_rx #(
        .FILTER_LEN (4),
        .TIMEOUT    (4096),
        .FIFO_AW    (2)
    ) dut (
        .clk_core    (clk_core),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .err_clear   (err_clear),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .clk_inhibit (clk_inhibit)
    );

    always #5 clk_core = ~clk_core;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb [$];

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        bit         glitch;
        bit         exp_push;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_core);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                             input bit glitch, input int half, input int first, input int last);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = d;
        f[9]   = ~(^d) ^ bad_par;
        f[10]  = ~bad_stop;
        for (int i = first; i <= last; i++) begin
            ps2_data = f[i];
            if (glitch) begin
                cyc(half / 2); ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(half - half / 2 - 2);
            end else begin
                cyc(half);
            end
            ps2_clk = 1'b0;
            if (glitch) begin
                cyc(half / 2); ps2_clk = 1'b1; cyc(2); ps2_clk = 1'b0; cyc(half - half / 2 - 2);
            end else begin
                cyc(half);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cyc(half);
    endtask

    task automatic send_good(input logic [7:0] d, input int half);
        sb.push_back(d);
        send_bits(d, 1'b0, 1'b0, 1'b0, half, 0, 10);
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp;
        int         w;
        w = 0;
        while (!rx_valid && w < 200) begin
            cyc(1);
            w++;
        end
        if (!rx_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: rx_valid never rose, expected a byte", name);
        end else if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got byte 0x%0h, expected none", name, rx_data);
        end else begin
            exp = sb.pop_front();
            check(name, 32'(rx_data), 32'(exp));
            rx_ack = 1'b1;
            cyc(1);
            rx_ack = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
        cyc(1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        cyc(3);
        check("reset_outputs", {19'd0, rx_data, rx_valid, parity_err, frame_err, overrun, clk_inhibit}, 32'd0);
        reset_n = 1'b1;
        cyc(5);

        // Basic frame at the nominal bit period
        send_good(8'h1C, 300);
        cyc(5);
        check("t1_valid", 32'(rx_valid), 32'd1);
        check("t1_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
        pop_check("t1_data");
        check("t1_valid_after_ack", 32'(rx_valid), 32'd0);

        // Table of good and bad frames; errors clear between entries
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].exp_push) sb.push_back(vecs[i].data);
            send_bits(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, vecs[i].glitch, 50, 0, 10);
            cyc(5);
            check($sformatf("vec%0d_perr", i), 32'(parity_err), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'(vecs[i].exp_push));
            if (vecs[i].exp_push) pop_check($sformatf("vec%0d_data", i));
            pulse_clear();
            check($sformatf("vec%0d_cleared", i), {30'd0, parity_err, frame_err}, 32'd0);
        end

        // Fill the FIFO, force one more frame in, then drain
        send_good(8'h11, 50);
        send_good(8'h22, 50);
        send_good(8'h33, 50);
        cyc(3);
        check("t3_inhibit_3", 32'(clk_inhibit), 32'd0);
        send_good(8'h44, 50);
        cyc(3);
        check("t3_inhibit_4", 32'(clk_inhibit), 32'd1);
        force dut.clk_inhibit = 1'b0;
        send_bits(8'h55, 1'b0, 1'b0, 1'b0, 50, 0, 10);
        cyc(3);
        release dut.clk_inhibit;
        cyc(2);
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_inhibit_full", 32'(clk_inhibit), 32'd1);
        pop_check("t3_pop0");
        cyc(1);
        check("t3_inhibit_drop", 32'(clk_inhibit), 32'd0);
        pop_check("t3_pop1");
        pop_check("t3_pop2");
        pop_check("t3_pop3");
        check("t3_empty", 32'(rx_valid), 32'd0);
        pulse_clear();
        check("t3_overrun_cleared", 32'(overrun), 32'd0);

        // Truncated frame runs into the inter-bit timeout
        send_bits(8'hF0, 1'b0, 1'b0, 1'b0, 50, 0, 4);
        cyc(5000);
        check("t4_ferr", 32'(frame_err), 32'd1);
        check("t4_no_push", 32'(rx_valid), 32'd0);
        pulse_clear();
        send_good(8'hF0, 50);
        cyc(3);
        check("t4_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
        pop_check("t4_data");

        // Mid-frame reset with a buffered byte and a pending flag
        send_good(8'h66, 50);
        send_bits(8'h5A, 1'b1, 1'b0, 1'b0, 50, 0, 10);
        cyc(3);
        check("t6_pre_state", {30'd0, rx_valid, parity_err}, 32'd3);
        send_bits(8'h34, 1'b0, 1'b0, 1'b0, 50, 0, 3);
        reset_n = 1'b0;
        cyc(3);
        check("t6_reset_outputs", {19'd0, rx_data, rx_valid, parity_err, frame_err, overrun, clk_inhibit}, 32'd0);
        reset_n = 1'b1;
        sb.delete();
        send_bits(8'h34, 1'b0, 1'b0, 1'b0, 50, 4, 10);
        cyc(5000);
        check("t6_tail_no_push", 32'(rx_valid), 32'd0);
        pulse_clear();
        send_good(8'h12, 50);
        pop_check("t6_data");
        check("t6_empty", 32'(rx_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
